// File: rtl/sweep_sequencer_if.sv
// Signal bundle between the sweep sequencer and its MMCM, sample FIFO, golden ROM and result store.
interface sweep_sequencer_if #(
  parameter int AddrWL = 11,
  parameter int DW     = 18
);
  logic              start;
  logic              abort;
  logic              cfg_req;
  logic [3:0]        cfg_step;
  logic              mmcm_lock;
  logic              dut_en;
  logic              fifo_clear;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DW-1:0]     fifo_dout;
  logic [AddrWL-1:0] gold_addr;
  logic [DW-1:0]     gold_data;
  logic              res_we;
  logic [3:0]        res_addr;
  logic [AddrWL:0]   res_data;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, mmcm_lock, fifo_empty, fifo_dout, gold_data,
    output cfg_req, cfg_step, dut_en, fifo_clear, fifo_rd_en, gold_addr,
           res_we, res_addr, res_data, busy, done
  );

  modport slave (
    output start, abort, mmcm_lock, fifo_empty, fifo_dout, gold_data,
    input  cfg_req, cfg_step, dut_en, fifo_clear, fifo_rd_en, gold_addr,
           res_we, res_addr, res_data, busy, done
  );
endinterface

// File: rtl/sweep_sequencer.sv
// Frequency-sweep sequencer: per step reconfigures the MMCM, flushes the FIFO, compares one run of
// DUT samples against the golden ROM and writes the per-step error count.
module sweep_sequencer #(
  parameter int AddrWL  = 11,
  parameter int DW      = 18,
  parameter int NSTEP   = 16,
  parameter int LOCK_TO = 65535,
  parameter int RUN_TO  = 1048575
) (
  input logic               clk,
  input logic               nrst,
  sweep_sequencer_if.master bus
);
  localparam int CW  = AddrWL + 1;
  localparam int WCW = ($clog2(LOCK_TO + 1) > 5) ? $clog2(LOCK_TO + 1) : 5;
  localparam int RCW = ($clog2(RUN_TO + 1) > 1) ? $clog2(RUN_TO + 1) : 1;
  localparam logic [CW-1:0]  NSAMP     = {1'b1, {AddrWL{1'b0}}};
  localparam logic [WCW-1:0] LOCK_LIM  = WCW'(LOCK_TO);
  localparam logic [WCW-1:0] LOCK_IGN  = WCW'(8);
  localparam logic [WCW-1:0] CLR_END   = WCW'(15);
  localparam logic [RCW-1:0] RUN_LIM   = RCW'(RUN_TO);
  localparam logic [3:0]     LAST_STEP = 4'(NSTEP - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG       = 3'd1,
    WAIT_LOCK = 3'd2,
    CLEAR     = 3'd3,
    RUN       = 3'd4,
    REPORT    = 3'd5,
    FIN       = 3'd6
  } state_t;

  state_t         r_state, w_nxt;
  logic           r_rst_sync;
  logic [3:0]     r_step, w_step;
  logic [WCW-1:0] r_wait_cnt, w_wait_cnt;
  logic [RCW-1:0] r_wd_cnt, w_wd_cnt;
  logic [CW-1:0]  r_rd_cnt, w_rd_cnt;
  logic [CW-1:0]  r_err, w_err, w_err_cmp;
  logic           r_rd_vld, r_cfg_req, r_dut_en, r_fifo_clear, r_res_we, r_busy;
  logic           r_done, w_done;
  logic           w_rd_en, w_mis, w_wd_exp;

  assign w_wd_exp  = (r_state == RUN) && (r_wd_cnt >= RUN_LIM);
  assign w_mis     = r_rd_vld && (bus.fifo_dout != bus.gold_data);
  assign w_err_cmp = (w_mis && (r_err != NSAMP)) ? r_err + CW'(1'b1) : r_err;
  assign w_rd_en   = (r_state == RUN) && !bus.abort && !bus.fifo_empty &&
                     (r_rd_cnt < NSAMP) && !w_wd_exp;

  // Next-state and counter update logic; held in reset until the release flop has seen nrst high.
  always_comb begin
    w_nxt      = r_state;
    w_step     = r_step;
    w_wait_cnt = '0;
    w_wd_cnt   = r_wd_cnt;
    w_rd_cnt   = r_rd_cnt;
    w_err      = r_err;
    w_done     = r_done;
    if (!r_rst_sync) begin
      w_nxt    = IDLE;
      w_step   = 4'd0;
      w_wd_cnt = '0;
      w_rd_cnt = '0;
      w_err    = '0;
      w_done   = 1'b0;
    end else if ((r_state != IDLE) && bus.abort) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            w_nxt  = CFG;
            w_step = 4'd0;
            w_done = 1'b0;
          end else begin
            w_nxt = IDLE;
          end
        end
        CFG: w_nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if ((r_wait_cnt >= LOCK_IGN) && bus.mmcm_lock) begin
            w_nxt = CLEAR;
          end else if (r_wait_cnt >= LOCK_LIM) begin
            w_nxt = REPORT;
            w_err = NSAMP;
          end else begin
            w_wait_cnt = r_wait_cnt + WCW'(1'b1);
          end
        end
        CLEAR: begin
          if (r_wait_cnt == CLR_END) begin
            w_nxt    = RUN;
            w_rd_cnt = '0;
            w_err    = '0;
            w_wd_cnt = '0;
          end else begin
            w_wait_cnt = r_wait_cnt + WCW'(1'b1);
          end
        end
        RUN: begin
          w_err = w_err_cmp;
          if (w_rd_en) begin
            w_rd_cnt = r_rd_cnt + CW'(1'b1);
            w_wd_cnt = '0;
          end else begin
            w_wd_cnt = r_wd_cnt + RCW'(1'b1);
          end
          // A stalled FIFO counts every sample never delivered as an error.
          if (w_wd_exp) begin
            w_err = w_err_cmp + (NSAMP - r_rd_cnt);
            w_nxt = REPORT;
          end else if (r_rd_vld && (r_rd_cnt == NSAMP)) begin
            w_nxt = REPORT;
          end else begin
            w_nxt = RUN;
          end
        end
        REPORT: begin
          if (r_step == LAST_STEP) begin
            w_nxt = FIN;
          end else begin
            w_step = r_step + 4'd1;
            w_nxt  = CFG;
          end
        end
        FIN: begin
          w_nxt  = IDLE;
          w_done = 1'b1;
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  // Reset release flop: logic leaves reset on the second edge after nrst rises.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_rst_sync <= 1'b0;
    else       r_rst_sync <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  // Counters and outputs decoded from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_step       <= 4'd0;
      r_wait_cnt   <= '0;
      r_wd_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_err        <= '0;
      r_rd_vld     <= 1'b0;
      r_cfg_req    <= 1'b0;
      r_dut_en     <= 1'b0;
      r_fifo_clear <= 1'b0;
      r_res_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_step       <= w_step;
      r_wait_cnt   <= w_wait_cnt;
      r_wd_cnt     <= w_wd_cnt;
      r_rd_cnt     <= w_rd_cnt;
      r_err        <= w_err;
      r_rd_vld     <= w_rd_en;
      r_cfg_req    <= (w_nxt == CFG);
      r_dut_en     <= (w_nxt == RUN);
      r_fifo_clear <= (w_nxt == CLEAR);
      r_res_we     <= (w_nxt == REPORT);
      r_busy       <= (w_nxt != IDLE);
      r_done       <= w_done;
    end
  end

  assign bus.cfg_req    = r_cfg_req;
  assign bus.cfg_step   = r_step;
  assign bus.dut_en     = r_dut_en;
  assign bus.fifo_clear = r_fifo_clear;
  assign bus.fifo_rd_en = w_rd_en;
  assign bus.gold_addr  = r_rd_cnt[AddrWL-1:0];
  assign bus.res_we     = r_res_we;
  assign bus.res_addr   = r_step;
  assign bus.res_data   = r_err;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: behavioural MMCM/FIFO/ROM models, a table of full sweeps,
// and hand-written abort and reset sequences.
module tb_sweep_sequencer;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  sweep_sequencer_if #(.AddrWL(AW), .DW(DW)) bus ();

  sweep_sequencer #(
    .AddrWL(AW), .DW(DW), .NSTEP(2), .LOCK_TO(100), .RUN_TO(50)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] mask0;
    logic [15:0] mask1;
    int          stall;
    logic        lock_ok;
    logic [4:0]  exp0;
    logic [4:0]  exp1;
  } vec_t;

  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;

  logic [15:0] m0 = 16'h0000;
  logic [15:0] m1 = 16'h0000;
  int          stall = 16;
  logic        lock_ok = 1'b1;
  int          base_cfg = 0;

  // Monitor state (written only by the monitor process)
  logic [3:0] wq_addr[$];
  logic [4:0] wq_data[$];
  int cfg_cnt = 0;
  int en_cnt = 0;
  int rd_empty = 0;

  int wr, rd, lk_cnt, step_idx;
  logic [15:0] cur_mask;
  logic [23:0] all_outs;

  function automatic logic [7:0] gold(input int i);
    return 8'(i * 7 + 3);
  endfunction

  assign step_idx = cfg_cnt - base_cfg - 1;
  assign cur_mask = (step_idx == 0) ? m0 : m1;
  assign bus.fifo_empty = (rd >= wr);
  assign all_outs = {bus.cfg_req, bus.cfg_step, bus.dut_en, bus.fifo_clear, bus.fifo_rd_en,
                     bus.gold_addr, bus.res_we, bus.res_addr, bus.res_data, bus.busy, bus.done};

  // MMCM model: lock drops on each reconfiguration and returns 20 cycles later if allowed
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus.mmcm_lock <= 1'b1;
      lk_cnt <= 0;
    end else if (bus.cfg_req) begin
      bus.mmcm_lock <= 1'b0;
      lk_cnt <= 20;
    end else if (lk_cnt > 0) begin
      lk_cnt <= lk_cnt - 1;
    end else begin
      bus.mmcm_lock <= lock_ok;
    end
  end

  // FIFO and golden ROM model: DUT writes one sample per enabled cycle up to the stall limit
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr <= 0;
      rd <= 0;
      bus.fifo_dout <= 8'h00;
      bus.gold_data <= 8'h00;
    end else begin
      bus.gold_data <= gold(int'(bus.gold_addr));
      if (bus.fifo_clear) begin
        wr <= 0;
        rd <= 0;
      end else begin
        if (bus.dut_en && (wr < stall)) wr <= wr + 1;
        if (bus.fifo_rd_en) begin
          bus.fifo_dout <= gold(rd) ^ (cur_mask[rd[3:0]] ? 8'h5A : 8'h00);
          rd <= rd + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.res_we) begin
      wq_addr.push_back(bus.res_addr);
      wq_data.push_back(bus.res_data);
    end
    if (bus.cfg_req) cfg_cnt = cfg_cnt + 1;
    if (bus.dut_en) en_cnt = en_cnt + 1;
    if (bus.fifo_rd_en && bus.fifo_empty) rd_empty = rd_empty + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, bw, ben, bcfg, bre;
    logic [3:0] a0, a1;
    logic [4:0] d0, d1;
    m0 = v.mask0;
    m1 = v.mask1;
    stall = v.stall;
    lock_ok = v.lock_ok;
    bw = wq_addr.size();
    ben = en_cnt;
    bcfg = cfg_cnt;
    bre = rd_empty;
    base_cfg = cfg_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    cyc = 0;
    while ((bus.done !== 1'b1) && (cyc < 3000)) begin
      tick();
      cyc++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    chk({tag, "_nwrites"}, 32'(wq_addr.size() - bw), 32'd2);
    a0 = (wq_addr.size() > bw) ? wq_addr[bw] : 4'hF;
    d0 = (wq_data.size() > bw) ? wq_data[bw] : 5'h1F;
    a1 = (wq_addr.size() > bw + 1) ? wq_addr[bw + 1] : 4'hF;
    d1 = (wq_data.size() > bw + 1) ? wq_data[bw + 1] : 5'h1F;
    chk({tag, "_addr0"}, 32'(a0), 32'd0);
    chk({tag, "_data0"}, 32'(d0), 32'(v.exp0));
    chk({tag, "_addr1"}, 32'(a1), 32'd1);
    chk({tag, "_data1"}, 32'(d1), 32'(v.exp1));
    chk({tag, "_dut_en_seen"}, 32'(en_cnt > ben), 32'(v.lock_ok));
    chk({tag, "_cfg_pulses"}, 32'(cfg_cnt - bcfg), 32'd2);
    chk({tag, "_rd_when_empty"}, 32'(rd_empty - bre), 32'd0);
  endtask

  initial begin
    int cyc, bw;
    vecs[0] = '{16'h0000, 16'h0000, 16, 1'b1, 5'd0,  5'd0};
    vecs[1] = '{16'h8008, 16'h0000, 16, 1'b1, 5'd2,  5'd0};
    vecs[2] = '{16'h0000, 16'h0000, 16, 1'b0, 5'd16, 5'd16};
    vecs[3] = '{16'h0020, 16'h0000, 10, 1'b1, 5'd7,  5'd6};
    vecs[4] = '{16'hFFFF, 16'h0421, 16, 1'b1, 5'd16, 5'd3};

    nrst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 32'(all_outs), 32'd0);

    // Release: start held across the first edge is ignored, taken on the second
    nrst = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("release_edge1_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("release_edge2_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    chk("abort_cfg_busy", 32'(bus.busy), 32'd0);
    bus.abort = 1'b0;
    for (int i = 0; i < 25; i++) tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort in RUN, then abort together with start in IDLE
    bw = wq_addr.size();
    base_cfg = cfg_cnt;
    lock_ok = 1'b1;
    stall = 16;
    m0 = 16'h0000;
    m1 = 16'h0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while ((bus.dut_en !== 1'b1) && (cyc < 200)) begin
      tick();
      cyc++;
    end
    chk("abort_reached_run", 32'(bus.dut_en), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_dut_en", 32'(bus.dut_en), 32'd0);
    chk("abort_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("abort_cfg_req", 32'(bus.cfg_req), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    tick();
    chk("abort_start_ignored", 32'(bus.busy), 32'd0);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("abort_no_write", 32'(wq_addr.size() - bw), 32'd0);
    chk("abort_done_held", 32'(bus.done), 32'd0);

    // Asynchronous reset in the middle of CLEAR
    bw = wq_addr.size();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while ((bus.fifo_clear !== 1'b1) && (cyc < 200)) begin
      tick();
      cyc++;
    end
    chk("areset_reached_clear", 32'(bus.fifo_clear), 32'd1);
    tick();
    tick();
    #2;
    nrst = 1'b0;
    #1;
    chk("areset_outputs", 32'(all_outs), 32'd0);
    tick();
    tick();
    chk("areset_no_write", 32'(wq_addr.size() - bw), 32'd0);
    nrst = 1'b1;
    tick();
    tick();
    run_vec(vecs[1], "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sweep_sequencer.md
SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 SHALL have parameter AddrWL, default 11, sample-address width; one run is 2^AddrWL samples.
REQ-002 SHALL have parameter DW, default 18, DUT output data width.
REQ-003 SHALL have parameter NSTEP, default 16, number of frequency steps, 2..16.
REQ-004 SHALL have parameter LOCK_TO, default 65535, lock-wait timeout in clk cycles.
REQ-005 SHALL have parameter RUN_TO, default 1048575, idle-FIFO watchdog in clk cycles.
REQ-006 Port list:
- clk  in  1  single clock; all logic on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; begins a sweep.
- abort  in  1  level; stops the sweep.
- cfg_req  out  1  1-cycle pulse requesting MMCM reconfiguration.
- cfg_step  out  4  frequency step index for cfg_req.
- mmcm_lock  in  1  MMCM locked, already synchronised to clk.
- dut_en  out  1  DUT enable.
- fifo_clear  out  1  async FIFO reset.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  FIFO read; data is valid 1 cycle later.
- fifo_dout  in  DW  FIFO read data.
- gold_addr  out  AddrWL  golden ROM address; data is valid 1 cycle later.
- gold_data  in  DW  golden ROM data.
- res_we  out  1  result write strobe.
- res_addr  out  4  result index, equal to the step.
- res_data  out  AddrWL+1  error count for the step.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next start.

Function
REQ-007 SHALL implement the states IDLE, CFG, WAIT_LOCK, CLEAR, RUN, REPORT and FIN.
REQ-008 In IDLE, start SHALL set step to 0, set done to 0 and move to CFG.
REQ-009 CFG SHALL pulse cfg_req for exactly 1 cycle, with cfg_step equal to step, then move to WAIT_LOCK.
REQ-010 WAIT_LOCK SHALL ignore mmcm_lock for the first 8 cycles, so that the lock deassertion can propagate.
REQ-011 After those 8 cycles, WAIT_LOCK SHALL move to CLEAR when mmcm_lock is 1.
REQ-012 If the WAIT_LOCK cycle count reaches LOCK_TO, the sequencer SHALL set the error count to 2^AddrWL and move to REPORT.
REQ-013 CLEAR SHALL assert fifo_clear for 16 cycles with dut_en at 0.
REQ-014 At the end of CLEAR, the sequencer SHALL zero the sample counter, the error counter and the watchdog, then move to RUN.
REQ-015 RUN SHALL hold dut_en at 1.
REQ-016 In RUN, fifo_rd_en SHALL be 1 when fifo_empty is 0 and the number of samples read is less than 2^AddrWL.
REQ-017 gold_addr SHALL equal the read index at the cycle of the read.
REQ-018 One cycle after each read, the sequencer SHALL compare fifo_dout with gold_data and increment the error counter on mismatch.
REQ-019 The error counter SHALL be AddrWL+1 bits wide and SHALL saturate at 2^AddrWL.
REQ-020 RUN SHALL move to REPORT on the cycle after the compare of the last sample.
REQ-021 The RUN watchdog SHALL reset on every read.
REQ-022 If the RUN watchdog reaches RUN_TO, the error counter SHALL be loaded with (error count + number of unread samples) and the sequencer SHALL move to REPORT.
REQ-023 On entry to REPORT, dut_en SHALL go to 0 in the same cycle.
REQ-024 REPORT SHALL pulse res_we for 1 cycle with res_addr equal to step and res_data equal to the error count.
REQ-025 After the REPORT write, if step equals NSTEP-1 the sequencer SHALL move to FIN; otherwise it SHALL increment step and move to CFG.
REQ-026 FIN SHALL set done to 1 and return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start SHALL be ignored while busy is 1.
REQ-029 abort in any non-IDLE state SHALL move to IDLE on the next cycle.
REQ-030 On abort, dut_en, fifo_rd_en and cfg_req SHALL go to 0, no res_we SHALL be issued, and done SHALL stay 0.
REQ-031 If abort and start are asserted together in IDLE, start SHALL be ignored.
REQ-032 fifo_rd_en SHALL never be 1 when fifo_empty is 1.

Reset
REQ-033 When nrst is 0, the state SHALL be IDLE, step 0 and all counters 0.
REQ-034 When nrst is 0, every output SHALL be 0, including fifo_clear, cfg_step, gold_addr, res_addr and res_data.
REQ-035 Reset in the middle of a sweep SHALL abandon the sweep with no result write.
REQ-036 Reset SHALL take effect asynchronously.
REQ-037 Reset SHALL be released synchronously; the first start is accepted on the second clk edge after nrst rises.

Verification
REQ-038 Full sweep: NSTEP=2, AddrWL=4, FIFO data matches ROM -> two res_we pulses (addr 0 then 1), res_data 0 each, then done=1.
REQ-039 Mismatch: samples 3 and 15 corrupted at step 0 -> res_data 2 at res_addr 0.
REQ-040 Lock timeout: mmcm_lock held 0, LOCK_TO=100 -> res_data 16 (AddrWL=4), no dut_en, sequencer continues to the next step.
REQ-041 Watchdog: FIFO stalls after 10 samples with 1 error, RUN_TO=50 -> res_data 7.
REQ-042 Abort in RUN -> next cycle IDLE, dut_en 0, busy 0, no res_we, done 0; start in the same cycle as abort is ignored.
REQ-043 Async reset mid-CLEAR -> all outputs 0 immediately; a restart after reset completes a full sweep normally.
